// File: rtl/uart_word_loader.sv
// Packs little-endian bytes from the UART receiver into 32-bit words and writes
// them to instruction memory, flagging parity faults and overruns.
module uart_word_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int WORD_COUNT     = 1024,
  parameter int TIMEOUT_CYCLES = 52080
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_parity_error,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  input  logic                  wr_ready,
  output logic [1:0]            byte_count,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]       IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(WORD_COUNT - 1);

  typedef enum logic [1:0] {S_COLLECT, S_WRITE, S_DONE, S_ERROR} state_t;

  state_t        state;
  logic [TW-1:0] idle_count;
  logic          rx_take;
  logic          expire;
  logic [1:0]    lane;

  assign rx_take = rx_valid && enable;
  assign expire  = enable && (byte_count != 2'd0) && (idle_count == IDLE_LAST);
  // A byte arriving on the expiry cycle starts a fresh word at lane 0.
  assign lane    = expire ? 2'd0 : byte_count;
  assign busy    = (byte_count != 2'd0) || (state == S_WRITE);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= S_COLLECT;
      idle_count   <= '0;
      byte_count   <= 2'd0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 32'd0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else if (clear) begin
      state        <= S_COLLECT;
      idle_count   <= '0;
      byte_count   <= 2'd0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (rx_take && rx_parity_error) begin
            state      <= S_ERROR;
            error      <= 1'b1;
            byte_count <= 2'd0;
            idle_count <= '0;
          end else if (rx_take) begin
            wr_data[8*lane +: 8] <= rx_data;
            idle_count           <= '0;
            if (lane == 2'd3) begin
              byte_count <= 2'd0;
              state      <= S_WRITE;
              wr_en      <= 1'b1;
            end else begin
              byte_count <= lane + 2'd1;
            end
          end else if (expire) begin
            byte_count <= 2'd0;
            idle_count <= '0;
          end else if (enable && (byte_count != 2'd0)) begin
            idle_count <= idle_count + 1'b1;
          end
        end
        S_WRITE: begin
          // A byte landing while the word is still unwritten means data was lost.
          if (rx_take) begin
            state <= S_ERROR;
            error <= 1'b1;
            wr_en <= 1'b0;
          end else if (wr_ready) begin
            wr_en        <= 1'b0;
            wr_addr      <= wr_addr + 1'b1;
            words_loaded <= words_loaded + 1'b1;
            if (words_loaded == LAST_WORD) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        default: begin
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
